// File: rtl/button_event_decoder.sv
// Per-channel button conditioner: 2-flop sync, debounce, short/long press classification.
// Latency: level and press/release pulses 2+DEBOUNCE_CYCLES cycles after a raw edge; long_pulse LONG_CYCLES after press.
// Backpressure: none; all outputs are free-running registered levels and single-cycle pulses.
module button_event_decoder #(
    parameter int NUM_BUTTONS     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 6000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] short_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    // Raw pin value when the button is not pressed; XOR with it normalises to 1 = pressed.
    localparam logic RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_RELEASED = 2'b00;
    localparam logic [1:0] ST_PRESSED  = 2'b01;
    localparam logic [1:0] ST_HELD     = 2'b10;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          sync;
        logic [DW-1:0] db_cnt;
        logic          level;
        logic          accept;
        logic          press_acc;
        logic          rel_acc;
        logic [1:0]    state;
        logic [HW-1:0] hold_cnt;
        logic          press_q;
        logic          release_q;
        logic          short_q;
        logic          long_q;

        // Two-flop synchroniser; reset loads the released pin value so no phantom press appears.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1 <= RELEASED_PIN;
                sync2 <= RELEASED_PIN;
            end else begin
                sync1 <= btn_raw[i];
                sync2 <= sync1;
            end
        end

        assign sync      = sync2 ^ RELEASED_PIN;
        assign accept    = (sync != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
        assign press_acc = accept && !level;
        assign rel_acc   = accept && level;

        // Debounce: count consecutive disagreeing samples; toggle the level after a full stable run.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (sync == level) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end

        // Press classifier; a release on the long-threshold cycle wins and reports as short.
        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= ST_RELEASED;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
                case (state)
                    ST_RELEASED: begin
                        if (press_acc) begin
                            state    <= ST_PRESSED;
                            hold_cnt <= '0;
                            press_q  <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (rel_acc) begin
                            state     <= ST_RELEASED;
                            release_q <= 1'b1;
                            short_q   <= 1'b1;
                        end else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
                            state    <= ST_HELD;
                            long_q   <= 1'b1;
                            hold_cnt <= hold_cnt + HW'(1);
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (rel_acc) begin
                            state     <= ST_RELEASED;
                            release_q <= 1'b1;
                        end else if (hold_cnt != HW'(LONG_CYCLES)) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    default: begin
                        state <= ST_RELEASED;
                    end
                endcase
            end
        end

        assign btn_level[i]     = level;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign short_pulse[i]   = short_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with short debounce/long thresholds.
// Latency: expected events carry the absolute cycle at which the pulse must appear.
// Backpressure: none; monitor checks every cycle any pulse output is non-zero.
module tb_button_event_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] btn_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] short_pulse;
    logic [1:0] long_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;

    typedef struct {
        int         cyc;
        logic [1:0] p;
        logic [1:0] r;
        logic [1:0] s;
        logic [1:0] l;
    } ev_t;

    ev_t sb[$];
    ev_t e;

    button_event_decoder #(
        .NUM_BUTTONS    (2),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-zero pulse vector must match the next expected event.
    always @(negedge clk) begin
        if ((press_pulse | release_pulse | short_pulse | long_pulse) != 2'b00) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d p=%b r=%b s=%b l=%b, expected no pulse",
                         cyc - base, press_pulse, release_pulse, short_pulse, long_pulse);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.p != press_pulse || e.r != release_pulse ||
                    e.s != short_pulse || e.l != long_pulse) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d p=%b r=%b s=%b l=%b, expected cyc=%0d p=%b r=%b s=%b l=%b",
                             cyc - base, press_pulse, release_pulse, short_pulse, long_pulse,
                             e.cyc - base, e.p, e.r, e.s, e.l);
                end
            end
        end
    end

    task automatic push(input int n, input logic [1:0] p, input logic [1:0] r,
                        input logic [1:0] s, input logic [1:0] l);
        ev_t x;
        x.cyc = base + n;
        x.p = p;
        x.r = r;
        x.s = s;
        x.l = l;
        sb.push_back(x);
    endtask

    // Advance to 1 time unit after relative edge n.
    task automatic goto(input int n);
        while (cyc < base + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc - base, got, exp);
        end
    endtask

    task automatic check_empty(input string name);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_events got=%0d expected=0 (next expected cyc=%0d)",
                     name, sb.size(), sb[0].cyc - base);
            sb.delete();
        end
    endtask

    task automatic do_reset(input bit chk);
        btn_raw = 2'b11;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (chk)
                check("reset_outputs",
                      btn_level | press_pulse | release_pulse | short_pulse | long_pulse, 2'b00);
        end
        rst = 1'b0;
        base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=cyc%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: quiet outputs during and after reset.
        do_reset(1'b1);
        goto(50);
        check("idle_level", btn_level, 2'b00);
        check_empty("idle");

        // Clean short press on button_a.
        do_reset(1'b0);
        push(16, 2'b01, 2'b00, 2'b00, 2'b00);
        push(26, 2'b00, 2'b01, 2'b01, 2'b00);
        goto(10); btn_raw = 2'b10;
        goto(15); check("clean_level_pre", btn_level, 2'b00);
        goto(16); check("clean_level_rise", btn_level, 2'b01);
        goto(20); btn_raw = 2'b11;
        goto(25); check("clean_level_held", btn_level, 2'b01);
        goto(26); check("clean_level_fall", btn_level, 2'b00);
        goto(60);
        check_empty("clean");

        // Bounce on button_b: runs of 3 never reach the 4-sample threshold.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            goto(10 + 3 * i);
            btn_raw[1] = (i % 2 == 1);
        end
        goto(30); check("bounce_level_mid", btn_level, 2'b00);
        goto(60); check("bounce_level_end", btn_level, 2'b00);
        check_empty("bounce");

        // Long press on button_a.
        do_reset(1'b0);
        push(16, 2'b01, 2'b00, 2'b00, 2'b00);
        push(36, 2'b00, 2'b00, 2'b00, 2'b01);
        push(66, 2'b00, 2'b01, 2'b00, 2'b00);
        goto(10); btn_raw = 2'b10;
        goto(50); check("long_level_held", btn_level, 2'b01);
        goto(60); btn_raw = 2'b11;
        goto(100);
        check_empty("long");

        // Simultaneous press; button_a release lands on the long threshold while button_b goes long.
        do_reset(1'b0);
        push(16, 2'b11, 2'b00, 2'b00, 2'b00);
        push(36, 2'b00, 2'b01, 2'b01, 2'b10);
        push(56, 2'b00, 2'b10, 2'b00, 2'b00);
        goto(10); btn_raw = 2'b00;
        goto(30); btn_raw = 2'b01;
        goto(50); btn_raw = 2'b11;
        goto(100);
        check("simul_level_end", btn_level, 2'b00);
        check_empty("simul");

        // Reset mid-press: interrupted press is dropped silently, then re-detected.
        do_reset(1'b0);
        push(16, 2'b01, 2'b00, 2'b00, 2'b00);
        push(38, 2'b01, 2'b00, 2'b00, 2'b00);
        push(58, 2'b00, 2'b00, 2'b00, 2'b01);
        push(76, 2'b00, 2'b01, 2'b00, 2'b00);
        goto(10); btn_raw = 2'b10;
        goto(30); rst = 1'b1;
        goto(31); check("rst_mid_level", btn_level, 2'b00);
        goto(32); rst = 1'b0;
        goto(37); check("rst_repress_pre", btn_level, 2'b00);
        goto(38); check("rst_repress_rise", btn_level, 2'b01);
        goto(70); btn_raw = 2'b11;
        goto(110);
        check_empty("rst_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Input-side conditioner for the Tang Nano push buttons; drives clean events into the LED effect logic (e.g. rainbow_led) in place of the raw button_a/button_b pins.
- Per channel it synchronises the raw pin, debounces it, and classifies each press as short or long.
- Outputs are a level plus single-cycle event pulses.
- Runs on the 12 MHz board clock.

Parameters:
- NUM_BUTTONS, 2, number of independent button channels (bit 0 = button_a, bit 1 = button_b).
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (board default); 0 = active-high.
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); minimum 2.
- LONG_CYCLES, 6000000, held cycles after accepted press before long_pulse (500 ms); must exceed DEBOUNCE_CYCLES.

Ports:
- clk  in  1  12 MHz system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BUTTONS  asynchronous raw button pins.
- btn_level  out  NUM_BUTTONS  debounced level, 1 = pressed, polarity-normalised.
- press_pulse  out  NUM_BUTTONS  1-cycle pulse on accepted press.
- release_pulse  out  NUM_BUTTONS  1-cycle pulse on accepted release.
- short_pulse  out  NUM_BUTTONS  1-cycle pulse on a release that occurs before long_pulse fired.
- long_pulse  out  NUM_BUTTONS  1-cycle pulse when a press has been held LONG_CYCLES cycles.

Behaviour:
- Reset: all outputs 0; synchroniser flops load the released value; debounce and hold counters cleared; every channel FSM in RELEASED. rst dominates any in-flight event.
- Synchroniser: two flops per channel, then XOR with ACTIVE_LOW to give normalised sync (1 = pressed).
- Debounce counter, per channel, width $clog2(DEBOUNCE_CYCLES+1):
  - Cleared whenever sync == btn_level.
  - Increments on each cycle that sync != btn_level.
  - On the cycle it would reach DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
- Debounce latency: raw edge sampled at edge E0 gives btn_level changing at edge E0+2+DEBOUNCE_CYCLES.
- Debounce rejection: any glitch, or bounce train with no run of DEBOUNCE_CYCLES identical samples, produces no change and no pulse.
- Channel FSM states:
  - RELEASED -> PRESSED on accepted press: press_pulse = 1 in the same cycle btn_level first reads 1; hold counter cleared.
  - PRESSED: hold counter (width $clog2(LONG_CYCLES+1)) increments every cycle.
  - PRESSED -> HELD when hold counter reaches LONG_CYCLES-1: long_pulse = 1 for exactly one cycle, LONG_CYCLES cycles after the press_pulse cycle.
  - PRESSED -> RELEASED on accepted release: release_pulse = 1 and short_pulse = 1 in the same cycle.
  - HELD -> RELEASED on accepted release: release_pulse = 1, short_pulse = 0.
  - HELD: hold counter saturates; long_pulse never repeats within one press.
- Release and long threshold in the same cycle: release wins. short_pulse = 1, long_pulse = 0.
- Channels are fully independent. Simultaneous events on different bits are all reported in the same cycle.
- Pulses are registered outputs, never combinational from btn_raw.
- Reset mid-press: all outputs go to 0; FSM returns to RELEASED.
  - If the pin is still held after rst deasserts, a fresh press_pulse appears 2+DEBOUNCE_CYCLES cycles later.
  - No release_pulse or short_pulse is generated for the interrupted press.

Test Plan:
(bench overrides DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, NUM_BUTTONS=2)
- Reset check: hold rst 3 cycles with btn_raw=2'b11 -> all outputs 0 during and after reset; no pulses for 50 cycles.
- Clean press: drive btn_raw[0]=0 at edge 10, release (1) at edge 20 -> btn_level[0] rises at edge 16; press_pulse[0] at cycle 16; btn_level[0] falls at edge 26; release_pulse[0] and short_pulse[0] at cycle 26; long_pulse[0] never asserts.
- Bounce rejection: btn_raw[1] toggles low/high every 3 cycles for 30 cycles, then returns high -> btn_level[1] stays 0; no pulses on any output.
- Long press: btn_raw[0] low from edge 10 to edge 60 -> press_pulse at 16; long_pulse exactly once at 36; release_pulse at 66; short_pulse stays 0.
- Simultaneous and boundary cases:
  - Both buttons low at edge 10 -> press_pulse=2'b11 at cycle 16.
  - Release arranged so the accepted release lands on the long-threshold cycle (cycle 36) -> short_pulse=1 and long_pulse=0 in that cycle.
- Reset mid-operation: hold btn_raw[0] low, assert rst at cycle 30 (after press, before long) -> outputs clear; no release_pulse or short_pulse for that press; after rst drops at 32, press_pulse[0] at cycle 38.
